// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
//   Shared types and constants for the video subsystem.
//   - dma_state_t   : state encoding of the sprite attribute copier
//   - SPR_CODE_BASE : CPU address of the sprite code/flag bytes
//   - SPR_POS_BASE  : CPU address of the sprite coordinate bytes
//   - SPR_BYTES     : bytes in each of the two sprite attribute regions
//   - src_offset()  : zero-extends a byte index so it can be added to a
//                     16-bit base address
// -----------------------------------------------------------------------------
package video_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } dma_state_t;

   localparam logic [15:0] SPR_CODE_BASE = 16'h4FF0;
   localparam logic [15:0] SPR_POS_BASE  = 16'h5060;
   localparam int          SPR_BYTES     = 16;

   // Byte indices are at most 8 bits wide. The sum with a base address is
   // a plain 16-bit add, so carries above bit 15 are dropped.
   function automatic logic [15:0] src_offset(input logic [7:0] idx);
      return {8'h00, idx};
   endfunction

endpackage

// File: rtl/sprite_dma_if.sv
// -----------------------------------------------------------------------------
// sprite_dma_if
//   Bus bundle between sprite_dma, the CPU memory arbiter and the sprite
//   engine's attribute RAM write port.
//
//   Read side (request/grant):
//     mem_req   : copier requests a read of mem_addr
//     mem_addr  : read address, stable for as long as mem_req is high
//     mem_gnt   : arbiter accepts the request in this cycle
//     mem_rdata : read data, valid exactly one cycle after the grant cycle
//   A read transfers in the cycle where mem_req and mem_gnt are both high.
//   Once raised, mem_req and mem_addr do not change until that cycle; the
//   arbiter may hold mem_gnt low for any number of cycles. mem_gnt while
//   mem_req is low has no meaning and is ignored.
//
//   Write side (to sprite_top):
//     sprite_RAM_din : write data
//     wr_en          : one-cycle write strobe per byte, no back-pressure
//     RAM_addr       : write address (same as the source address)
//
//   Modports:
//     master : the copier (sprite_dma)
//     slave  : memory arbiter + attribute RAM side
// -----------------------------------------------------------------------------
interface sprite_dma_if;

   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt;
   logic [7:0]  mem_rdata;
   logic [7:0]  sprite_RAM_din;
   logic        wr_en;
   logic [15:0] RAM_addr;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rdata,
      output sprite_RAM_din,
      output wr_en,
      output RAM_addr
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rdata,
      input  sprite_RAM_din,
      input  wr_en,
      input  RAM_addr
   );

endinterface

// File: rtl/sprite_dma_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
//   Rising-edge detector for a level signal that is already synchronous to
//   clk (e.g. vblank or hblank from vga_ctrl).
//
//   Ports:
//     clk   in  : clock
//     rst   in  : synchronous active-high reset, clears the history register
//     d     in  : level input
//     pulse out : high in the cycle where d is 1 and was 0 one cycle earlier
//
//   The history register resets to 0, so a level that is already high when
//   reset releases is reported as a rise in the first cycle after reset.
// -----------------------------------------------------------------------------
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign pulse = d & ~d_q;

endmodule

// File: rtl/sprite_dma.sv
// -----------------------------------------------------------------------------
// sprite_dma
//   Vblank-triggered copier for the sprite attribute bytes. On each rising
//   edge of vblank (if en is high and the copier is idle) it reads N_BYTES
//   bytes from SRC0_BASE upward, then N_BYTES bytes from SRC1_BASE upward,
//   and writes each one to sprite_top at the same address it was read from.
//   Copying only in vertical blank keeps the sprites from tearing mid-frame.
//
//   Parameters:
//     SRC0_BASE : first source region (sprite codes/flags)
//     SRC1_BASE : second source region (sprite coordinates)
//     N_BYTES   : bytes per region, a power of two no larger than 256
//
//   Ports:
//     clk       in  : system clock (shared with vga_ctrl and sprite_top)
//     rst       in  : synchronous active-high reset
//     en        in  : transfer enable, only looked at on the vblank rise
//     vblank    in  : vertical blank level from vga_ctrl
//     bus       mst : read request/grant port and attribute RAM write port
//     busy      out : high from the first REQ cycle through the DONE cycle
//     done      out : one-cycle pulse after the last write
//     overrun   out : sticky, set when vblank falls while a copy is running;
//                     cleared only by reset
//     dbg_state out : current FSM state
//
//   Every output is decoded from the state register and the registered
//   idx/reg_sel/data_q/addr_q; nothing on the bus inputs reaches an output
//   combinationally.
// -----------------------------------------------------------------------------
module sprite_dma
   import video_pkg::*;
#(
   parameter logic [15:0] SRC0_BASE = SPR_CODE_BASE,
   parameter logic [15:0] SRC1_BASE = SPR_POS_BASE,
   parameter int          N_BYTES   = SPR_BYTES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                vblank,
   sprite_dma_if.master        bus,
   output logic                busy,
   output logic                done,
   output logic                overrun,
   output dma_state_t          dbg_state
);

   // A single-byte region still needs a one-bit counter.
   localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

   dma_state_t       state;
   dma_state_t       state_next;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_next;
   logic             reg_sel;
   logic             reg_sel_next;
   logic [7:0]       data_q;
   logic [15:0]      addr_q;
   logic [15:0]      src_addr;
   logic             vblank_rise;
   logic             vblank_fall;
   logic             start;

   // ---------------------------------------------------------------------
   // vblank edges. The falling edge is found as a rising edge of the
   // inverted level; its spurious pulse right after reset only matters
   // while busy, and busy is low then.
   // ---------------------------------------------------------------------
   rise_detect u_vblank_rise (
      .clk   (clk),
      .rst   (rst),
      .d     (vblank),
      .pulse (vblank_rise)
   );

   rise_detect u_vblank_fall (
      .clk   (clk),
      .rst   (rst),
      .d     (~vblank),
      .pulse (vblank_fall)
   );

   assign start = vblank_rise & en & (state == IDLE);

   // Source address of the byte currently being fetched.
   assign src_addr = (reg_sel ? SRC1_BASE : SRC0_BASE)
                   + src_offset(8'(idx));

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         reg_sel <= 1'b0;
         data_q  <= 8'h00;
         addr_q  <= 16'h0000;
         overrun <= 1'b0;
      end else begin
         state   <= state_next;
         idx     <= idx_next;
         reg_sel <= reg_sel_next;
         // mem_rdata belongs to the request granted in the previous cycle,
         // and idx/reg_sel have not moved since, so src_addr still matches.
         if (state == DATA) begin
            data_q <= bus.mem_rdata;
            addr_q <= src_addr;
         end
         if (vblank_fall && (state != IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      idx_next     = idx;
      reg_sel_next = reg_sel;

      case (state)
         IDLE: begin
            if (start) begin
               idx_next     = '0;
               reg_sel_next = 1'b0;
               state_next   = REQ;
            end
         end

         REQ: begin
            if (bus.mem_gnt) begin
               state_next = DATA;
            end
         end

         DATA: begin
            state_next = WRITE;
         end

         WRITE: begin
            if (idx == LAST_IDX) begin
               if (reg_sel) begin
                  state_next = DONE;
               end else begin
                  idx_next     = '0;
                  reg_sel_next = 1'b1;
                  state_next   = REQ;
               end
            end else begin
               idx_next   = idx + IDX_W'(1);
               state_next = REQ;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs, decoded from state. Address and data buses are forced to zero
   // outside their strobe so they sit at their reset value when idle.
   // ---------------------------------------------------------------------
   always_comb begin
      bus.mem_req        = 1'b0;
      bus.mem_addr       = 16'h0000;
      bus.wr_en          = 1'b0;
      bus.sprite_RAM_din = 8'h00;
      bus.RAM_addr       = 16'h0000;

      if (state == REQ) begin
         bus.mem_req  = 1'b1;
         bus.mem_addr = src_addr;
      end

      if (state == WRITE) begin
         bus.wr_en          = 1'b1;
         bus.sprite_RAM_din = data_q;
         bus.RAM_addr       = addr_q;
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_sprite_dma.sv
module tb_sprite_dma;
   import video_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic en     = 1'b0;
   logic vblank = 1'b0;
   logic busy;
   logic done;
   logic overrun;
   dma_state_t dbg_state;

   sprite_dma_if bus ();

   sprite_dma dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .vblank    (vblank),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   // ---------------- memory model ----------------
   // 0x4FF0+i holds i, 0x5060+i holds 0x80+i, everything else 0xEE.
   function automatic logic [7:0] mem_model(input logic [15:0] a);
      if (a >= 16'h4FF0 && a <= 16'h4FFF) return 8'(a - 16'h4FF0);
      else if (a >= 16'h5060 && a <= 16'h506F) return 8'h80 + 8'(a - 16'h5060);
      else return 8'hEE;
   endfunction

   logic [15:0] stall_addr = 16'hFFFF;
   int          stall_len  = 0;
   int          stall_seen = 0;

   assign bus.mem_gnt = bus.mem_req &&
                        !((bus.mem_addr == stall_addr) && (stall_seen < stall_len));

   always @(posedge clk) begin
      if (!busy) stall_seen <= 0;
      else if (bus.mem_req && !bus.mem_gnt) stall_seen <= stall_seen + 1;
      // Data only on the cycle after a grant; filler otherwise.
      bus.mem_rdata <= bus.mem_gnt ? mem_model(bus.mem_addr) : 8'h5A;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [23:0] exp_q[$];
   int wr_count    = 0;
   int done_count  = 0;
   int req_count   = 0;
   int last_wr_cyc = 0;
   int done_cyc    = 0;

   always @(negedge clk) begin
      if (bus.wr_en) begin
         logic [23:0] e;
         wr_count++;
         last_wr_cyc = cyc;
         check("write_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_addr_data", {8'h00, bus.RAM_addr, bus.sprite_RAM_din}, {8'h00, e});
         end
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
      if (bus.mem_req) req_count++;
   end

   // ---------------- driver tasks ----------------
   task automatic push_bytes(input int n);
      for (int k = 0; k < n; k++) begin
         logic [15:0] a;
         a = (k < 16) ? 16'h4FF0 + 16'(k) : 16'h5060 + 16'(k - 16);
         exp_q.push_back({a, mem_model(a)});
      end
   endtask

   task automatic start_vblank(output int n);
      @(posedge clk);
      #1 vblank = 1'b1;
      n = cyc;
   endtask

   task automatic wait_cyc(input int t);
      do @(negedge clk); while (cyc < t);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < budget);
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      vblank = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int w0;
      int d0;
      int r0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_din", 32'(bus.sprite_RAM_din), 32'd0);
      check("rst_ram_addr", 32'(bus.RAM_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1 rst = 1'b0;
      en = 1'b1;

      // 1: full copy, immediate grants
      push_bytes(32);
      w0 = wr_count;
      d0 = done_count;
      start_vblank(n);
      @(negedge clk);
      check("t1_busy_at_n", 32'(busy), 32'd0);
      @(negedge clk);
      check("t1_busy_n1", 32'(busy), 32'd1);
      check("t1_req_n1", 32'(bus.mem_req), 32'd1);
      check("t1_addr_n1", 32'(bus.mem_addr), 32'h4FF0);
      wait_idle("t1_idle", 200);
      check("t1_busy_fall", 32'(cyc), 32'(n + 98));
      check("t1_last_wr", 32'(last_wr_cyc), 32'(n + 96));
      check("t1_done_cyc", 32'(done_cyc), 32'(n + 97));
      check("t1_wr_count", 32'(wr_count - w0), 32'd32);
      check("t1_done_count", 32'(done_count - d0), 32'd1);
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t1_overrun", 32'(overrun), 32'd0);
      @(posedge clk);
      #1 vblank = 1'b0;
      repeat (2) @(negedge clk);
      check("t1_overrun_idle_fall", 32'(overrun), 32'd0);

      // 2: grant held off 5 cycles on byte 3
      stall_addr = 16'h4FF3;
      stall_len  = 5;
      push_bytes(32);
      w0 = wr_count;
      start_vblank(n);
      wait_cyc(n + 10);
      for (int i = 0; i < 6; i++) begin
         check("t2_stall_req", 32'(bus.mem_req), 32'd1);
         check("t2_stall_addr", 32'(bus.mem_addr), 32'h4FF3);
         @(negedge clk);
      end
      check("t2_data_after_gnt", 32'(dbg_state), 32'(DATA));
      wait_idle("t2_idle", 200);
      check("t2_last_wr", 32'(last_wr_cyc), 32'(n + 101));
      check("t2_done_cyc", 32'(done_cyc), 32'(n + 102));
      check("t2_wr_count", 32'(wr_count - w0), 32'd32);
      stall_len = 0;
      @(posedge clk);
      #1 vblank = 1'b0;

      // 3: vblank only 40 cycles -> copy completes, overrun sticks
      push_bytes(32);
      w0 = wr_count;
      start_vblank(n);
      wait_cyc(n + 40);
      @(posedge clk);
      #1 vblank = 1'b0;
      wait_cyc(n + 42);
      check("t3_overrun_set", 32'(overrun), 32'd1);
      wait_idle("t3_idle", 200);
      check("t3_done_cyc", 32'(done_cyc), 32'(n + 97));
      check("t3_wr_count", 32'(wr_count - w0), 32'd32);
      check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
      repeat (20) @(negedge clk);
      check("t3_overrun_sticky", 32'(overrun), 32'd1);
      apply_reset();
      @(negedge clk);
      check("t3_overrun_cleared", 32'(overrun), 32'd0);

      // 4: en low at the rise -> nothing happens this frame
      en = 1'b0;
      r0 = req_count;
      w0 = wr_count;
      start_vblank(n);
      wait_cyc(n + 10);
      @(posedge clk);
      #1 en = 1'b1;
      repeat (100) @(negedge clk);
      check("t4_no_req", 32'(req_count - r0), 32'd0);
      check("t4_no_write", 32'(wr_count - w0), 32'd0);
      check("t4_idle", 32'(busy), 32'd0);
      @(posedge clk);
      #1 vblank = 1'b0;

      // 5: second vblank rise while busy is ignored
      push_bytes(32);
      w0 = wr_count;
      d0 = done_count;
      start_vblank(n);
      wait_cyc(n + 20);
      @(posedge clk);
      #1 vblank = 1'b0;
      wait_cyc(n + 30);
      @(posedge clk);
      #1 vblank = 1'b1;
      wait_idle("t5_idle", 200);
      check("t5_done_cyc", 32'(done_cyc), 32'(n + 97));
      check("t5_wr_count", 32'(wr_count - w0), 32'd32);
      check("t5_done_count", 32'(done_count - d0), 32'd1);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1 vblank = 1'b0;
      repeat (5) @(negedge clk);
      check("t5_no_restart", 32'(busy), 32'd0);
      apply_reset();

      // 6: reset during the WRITE of byte 10, then a clean full copy
      push_bytes(11);
      w0 = wr_count;
      start_vblank(n);
      wait_cyc(n + 33);
      check("t6_write_state", 32'(dbg_state), 32'(WRITE));
      rst    = 1'b1;
      vblank = 1'b0;
      @(negedge clk);
      check("t6_wr_en_after_rst", 32'(bus.wr_en), 32'd0);
      check("t6_busy_after_rst", 32'(busy), 32'd0);
      check("t6_wr_count", 32'(wr_count - w0), 32'd11);
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      push_bytes(32);
      w0 = wr_count;
      start_vblank(n);
      repeat (2) @(negedge clk);
      check("t6_restart_addr", 32'(bus.mem_addr), 32'h4FF0);
      wait_idle("t6_idle", 200);
      check("t6_full_wr_count", 32'(wr_count - w0), 32'd32);
      check("t6_done_cyc", 32'(done_cyc), 32'(n + 97));
      check("t6_final_queue", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1 vblank = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_dma.md
# sprite_dma

Vblank-triggered copier that moves the 32 sprite attribute bytes from the shared CPU memory into the sprite engine's attribute RAM. It sits directly upstream of `sprite_top` inside the video subsystem and drives its `sprite_RAM_din` / `wr_en` / `RAM_addr` write port. It copies sprite codes and flags at 0x4FF0–0x4FFF and coordinates at 0x5060–0x506F once per frame. Because the copy runs only during vertical blank, sprites never tear mid-frame.

## Interface
Parameters:
- `SRC0_BASE`, default 16'h4FF0: first source region (codes/flags).
- `SRC1_BASE`, default 16'h5060: second source region (coordinates).
- `N_BYTES`, default 16: bytes per region; must be a power of two, ≤ 256.

Ports:
- `clk` in 1: system clock, the same clock as `vga_ctrl` and `sprite_top`.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: transfer enable, sampled at vblank rise.
- `vblank` in 1: level from `vga_ctrl`.
- `mem_req` out 1: read request to memory arbiter.
- `mem_addr` out 16: read address, valid while `mem_req`=1.
- `mem_gnt` in 1: arbiter accepts the request this cycle.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after the `mem_gnt` cycle.
- `sprite_RAM_din` out 8: write data to `sprite_top`.
- `wr_en` out 1: write strobe, one cycle per byte.
- `RAM_addr` out 16: write address, equal to the source address.
- `busy` out 1: high from the start cycle until DONE completes.
- `done` out 1: one-cycle pulse after the last write.
- `overrun` out 1: sticky; set if vblank falls while `busy`=1.

## Operation
- Edge detect: `vblank_q` is a register of `vblank`. The start condition is `vblank & ~vblank_q & en & state==IDLE`.
- The FSM runs IDLE → REQ → DATA → WRITE → (REQ | DONE) → IDLE.
  - IDLE: all strobes low. On start, clear the byte counter `idx` to 0 and the region bit `reg_sel` to 0, then go to REQ.
  - REQ: drive `mem_req`=1 and `mem_addr` = (`reg_sel` ? `SRC1_BASE` : `SRC0_BASE`) + `idx`. Hold both stable until `mem_gnt`=1, then go to DATA.
  - DATA: capture `mem_rdata` into `data_q` and the address into `addr_q`. Go to WRITE.
  - WRITE: drive `wr_en`=1, `sprite_RAM_din`=`data_q`, `RAM_addr`=`addr_q` for exactly one cycle.
    - If `idx` = `N_BYTES`-1 and `reg_sel`=1, go to DONE.
    - If `idx` = `N_BYTES`-1 and `reg_sel`=0, set `idx`←0, `reg_sel`←1, go to REQ.
    - Otherwise `idx`←`idx`+1 and go to REQ.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Width rules: `idx` is $clog2(`N_BYTES`) bits. The address sum is a 16-bit add; wrap-around above 16'hFFFF is truncated and not flagged.
- Byte order is fixed: all of region 0 ascending, then all of region 1 ascending. Total 2·`N_BYTES` writes.
- Boundary behaviour:
  - Vblank falls mid-transfer: the transfer continues to completion and `overrun`←1.
  - Vblank rise while not IDLE: ignored, no restart.
  - `en` deasserted mid-transfer: no effect; it is only sampled at start.
  - `mem_gnt` high outside REQ: ignored.
  - `mem_gnt` stalls indefinitely: the FSM waits in REQ.
- Reset mid-operation: the FSM returns to IDLE on the next edge. The in-flight byte is not written. `overrun` clears.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `wr_en`=0, `sprite_RAM_din`=0, `RAM_addr`=0, `busy`=0, `done`=0, `overrun`=0, `vblank_q`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_rdata` or `mem_gnt` to any output.
- Start: vblank rises in cycle N. `busy` and `mem_req` are high from N+1.
- Per byte with an immediate grant: REQ (gnt) → DATA → WRITE, 3 cycles.
- Full transfer with no stalls: 96 writes-cycles span. The last `wr_en` is at N+96 and `done` is at N+97. `busy` falls at N+98.
- Each `mem_gnt` stall cycle adds exactly one cycle.

## Structure
- `video_pkg` holds the `dma_state_t` enum (IDLE, REQ, DATA, WRITE, DONE) and the constants `SPR_CODE_BASE`=16'h4FF0, `SPR_POS_BASE`=16'h5060, `SPR_BYTES`=16. The parameter defaults reference these constants.
- One sub-module, `rise_detect` (clk, rst, d → pulse). It is reused by any block needing a vblank or hblank edge.
- Integration: `vblank` comes from `vga_ctrl`. The `sprite_RAM_din`, `wr_en` and `RAM_addr` outputs connect to `sprite_top`.

## Test plan
- Memory model fills 0x4FF0+i with i and 0x5060+i with 0x80+i, with `mem_gnt` tied to `mem_req`. Pulse vblank → 32 writes in ascending order: 0x4FF0..0x4FFF carry 0x00..0x0F, 0x5060..0x506F carry 0x80..0x8F; `done` at N+97; `overrun`=0.
- `mem_gnt` low for 5 cycles on byte 3 → `mem_addr`=0x4FF3 is held stable, and the last write moves exactly 5 cycles later.
- Vblank high for only 40 cycles → all 32 writes still complete and `overrun`=1 stays high until `rst`.
- `en`=0 at vblank rise → no `mem_req` and no `wr_en` for the whole frame. A second vblank rise during `busy` → exactly 32 writes, no restart.
- `rst` asserted in the WRITE state of byte 10 → `wr_en`=0 and `busy`=0 the next cycle. The next vblank produces a full 32-byte copy starting at 0x4FF0.
